// File: rtl/lcd_mmio_ctrl.sv
// Memory-mapped HD44780 character-LCD controller: CPU writes queue in a FIFO, hardware drives the E strobe.
// Optional LCD_SIM_PRINT_EN: simulation echoes each completed data byte (rs=1) as a character.
module lcd_mmio_ctrl #(
   parameter int FIFO_DEPTH       = 8,
   parameter int NIBBLE_MODE      = 0,
   parameter int SETUP_CYCLES     = 2,
   parameter int PULSE_CYCLES     = 4,
   parameter int HOLD_CYCLES      = 2,
   parameter int CMD_WAIT_CYCLES  = 8,
   parameter int LONG_WAIT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_sel,
   input  logic [3:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   input  logic [3:0]  bus_wenable,
   output logic [31:0] bus_rdata,
   output logic [7:0]  lcd_data,
   output logic [1:0]  lcd_ctrl,
   output logic        lcd_enable,
   output logic        irq_idle
);

   // state | meaning
   // IDLE  | waiting for a FIFO entry; pops and latches it
   // SETUP | data/ctrl stable, E low
   // PULSE | E high
   // HOLD  | E low, data/ctrl held; nibble mode re-enters SETUP once
   // WAIT  | LCD execution time before the next transfer
   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT} state_t;

   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int LVW    = AW + 1;
   localparam int S_EFF  = (SETUP_CYCLES     < 1) ? 1 : SETUP_CYCLES;
   localparam int P_EFF  = (PULSE_CYCLES     < 1) ? 1 : PULSE_CYCLES;
   localparam int H_EFF  = (HOLD_CYCLES      < 1) ? 1 : HOLD_CYCLES;
   localparam int CW_EFF = (CMD_WAIT_CYCLES  < 1) ? 1 : CMD_WAIT_CYCLES;
   localparam int LW_EFF = (LONG_WAIT_CYCLES < 1) ? 1 : LONG_WAIT_CYCLES;
   localparam int M1     = (S_EFF > P_EFF) ? S_EFF : P_EFF;
   localparam int M2     = (M1 > H_EFF) ? M1 : H_EFF;
   localparam int M3     = (M2 > CW_EFF) ? M2 : CW_EFF;
   localparam int MAXC   = (M3 > LW_EFF) ? M3 : LW_EFF;
   localparam int CNTW   = $clog2(MAXC + 1);

   localparam logic [CNTW-1:0] S_LD  = CNTW'(S_EFF - 1);
   localparam logic [CNTW-1:0] P_LD  = CNTW'(P_EFF - 1);
   localparam logic [CNTW-1:0] H_LD  = CNTW'(H_EFF - 1);
   localparam logic [CNTW-1:0] CW_LD = CNTW'(CW_EFF - 1);
   localparam logic [CNTW-1:0] LW_LD = CNTW'(LW_EFF - 1);

   logic [8:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LVW-1:0]  level_q;
   logic            ovf_q;
   state_t          state_q;
   logic [CNTW-1:0] cnt_q;
   logic [7:0]      byte_q;
   logic            rs_q;
   logic            nib_lo_q;
   logic [7:0]      lcd_data_q;
   logic            en_q;
   logic [31:0]     rdata_q;

   logic       wr_en, push_req, push_ok, pop, full, empty, busy, long_wait;
   logic [8:0] head;
   logic [31:0] status;
   logic       unused_ok;

   assign wr_en     = bus_sel & bus_wenable[0];
   assign push_req  = wr_en & ~bus_addr[3];
   assign empty     = (level_q == '0);
   assign full      = (level_q == LVW'(FIFO_DEPTH));
   assign busy      = (state_q != ST_IDLE);
   assign pop       = (state_q == ST_IDLE) & ~empty;
   assign push_ok   = push_req & (~full | pop);
   assign head      = mem_q[rd_ptr_q];
   assign long_wait = ~rs_q & (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);
   assign status    = {16'd0, 8'(level_q), 4'd0, ovf_q, empty, full, busy};
   assign unused_ok = ^{bus_wdata[31:8], bus_wdata[7:4], bus_wdata[2:0], bus_wenable[3:1], bus_addr[1:0]};

   // DATA sits at offset 0 (addr[2]=0) and carries rs=1
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= {~bus_addr[2], bus_wdata[7:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push_ok && !pop)      level_q <= level_q + LVW'(1);
         else if (!push_ok && pop) level_q <= level_q - LVW'(1);
         if (push_req && !push_ok)
            ovf_q <= 1'b1;
         else if (wr_en && bus_addr[3:2] == 2'd2 && bus_wdata[3])
            ovf_q <= 1'b0;
         if (bus_sel) rdata_q <= (bus_addr[3:2] == 2'd2) ? status : 32'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         byte_q     <= '0;
         rs_q       <= 1'b0;
         nib_lo_q   <= 1'b0;
         lcd_data_q <= '0;
         en_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  rs_q       <= head[8];
                  byte_q     <= head[7:0];
                  lcd_data_q <= (NIBBLE_MODE != 0) ? {head[7:4], 4'b0} : head[7:0];
                  nib_lo_q   <= 1'b0;
                  cnt_q      <= S_LD;
                  state_q    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt_q == '0) begin
                  cnt_q   <= P_LD;
                  en_q    <= 1'b1;
                  state_q <= ST_PULSE;
               end else cnt_q <= cnt_q - CNTW'(1);
            end
            ST_PULSE: begin
               if (cnt_q == '0) begin
                  cnt_q   <= H_LD;
                  en_q    <= 1'b0;
                  state_q <= ST_HOLD;
               end else cnt_q <= cnt_q - CNTW'(1);
            end
            ST_HOLD: begin
               if (cnt_q == '0) begin
                  if (NIBBLE_MODE != 0 && !nib_lo_q) begin
                     nib_lo_q   <= 1'b1;
                     lcd_data_q <= {byte_q[3:0], 4'b0};
                     cnt_q      <= S_LD;
                     state_q    <= ST_SETUP;
                  end else begin
                     cnt_q   <= long_wait ? LW_LD : CW_LD;
                     state_q <= ST_WAIT;
                  end
               end else cnt_q <= cnt_q - CNTW'(1);
            end
            ST_WAIT: begin
               if (cnt_q == '0) state_q <= ST_IDLE;
               else             cnt_q   <= cnt_q - CNTW'(1);
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef LCD_SIM_PRINT_EN
   always @(posedge clk) begin
      if (rst_n && state_q == ST_PULSE && cnt_q == '0 && rs_q && (NIBBLE_MODE == 0 || nib_lo_q))
         $write("%c", byte_q);
   end
`endif

   assign bus_rdata  = rdata_q;
   assign lcd_data   = lcd_data_q;
   assign lcd_ctrl   = {rs_q, 1'b0};
   assign lcd_enable = en_q;
   assign irq_idle   = (state_q == ST_IDLE) & empty;

endmodule
